// File: rtl/iter_down_seq.sv
// Iteration sequencer for the iterative multiply/divide datapath: loads ITERS-1
// on a start request, steps down to 0 while enabled, then pulses done for one cycle.
module iter_down_seq #(
    parameter int CNT_W = 5,
    parameter int ITERS = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             en,
    output logic             op_div,
    output logic             busy,
    output logic             step,
    output logic [CNT_W-1:0] iter,
    output logic             first,
    output logic             last,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] ITER_MAX = CNT_W'(ITERS - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] iter_q, iter_nxt;
    logic             op_div_q, op_div_nxt;
    logic             err_q, err_nxt;
    logic             start;

    assign start = start_mult | start_div;

    // A start request preempts whatever the sequencer is doing, including DONE.
    always_comb begin
        state_nxt  = state;
        iter_nxt   = iter_q;
        op_div_nxt = op_div_q;
        err_nxt    = 1'b0;
        if (start) begin
            state_nxt  = RUN;
            iter_nxt   = ITER_MAX;
            op_div_nxt = start_div & ~start_mult;
            err_nxt    = start_mult & start_div;
        end else begin
            case (state)
                RUN: begin
                    if (en) begin
                        if (iter_q != '0) iter_nxt = iter_q - CNT_W'(1);
                        else              state_nxt = DONE;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            iter_q   <= '0;
            op_div_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            iter_q   <= iter_nxt;
            op_div_q <= op_div_nxt;
            err_q    <= err_nxt;
        end
    end

    // Outputs decode registered state only; en merely gates the step strobe.
    assign op_div = op_div_q;
    assign busy   = (state != IDLE);
    assign step   = (state == RUN) && en;
    assign iter   = iter_q;
    assign first  = step && (iter_q == ITER_MAX);
    assign last   = step && (iter_q == '0);
    assign done   = (state == DONE);
    assign err    = err_q;

endmodule

// File: tb/tb_iter_down_seq.sv
// Bench for iter_down_seq: directed and random runs against a step-counting model
// (ITERS=32), plus a vector table for the minimum ITERS=2 / CNT_W=1 build.
module tb_iter_down_seq;

    localparam int ITERS = 32;
    localparam int CNT_W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr, sm, sd, en;
    logic op_div, busy, step, first, last, done, err;
    logic [CNT_W-1:0] iter;

    logic clr2, sm2, sd2, en2;
    logic op_div2, busy2, step2, first2, last2, done2, err2;
    logic [0:0] iter2;

    iter_down_seq #(.CNT_W(CNT_W), .ITERS(ITERS)) dut (
        .clk(clk), .clr(clr), .start_mult(sm), .start_div(sd), .en(en),
        .op_div(op_div), .busy(busy), .step(step), .iter(iter),
        .first(first), .last(last), .done(done), .err(err)
    );

    iter_down_seq #(.CNT_W(1), .ITERS(2)) dut2 (
        .clk(clk), .clr(clr2), .start_mult(sm2), .start_div(sd2), .en(en2),
        .op_div(op_div2), .busy(busy2), .step(step2), .iter(iter2),
        .first(first2), .last(last2), .done(done2), .err(err2)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: "how many steps of the current operation have been taken".
    bit m_act, m_done, m_err, m_opd;
    int m_k;

    function automatic logic [11:0] model_out(input bit e);
        logic [4:0] it;
        bit s;
        s  = m_act && e;
        it = m_act ? 5'(ITERS - 1 - m_k) : 5'd0;
        return {m_opd, (m_act || m_done), s, it, (s && m_k == 0),
                (s && m_k == ITERS - 1), m_done, m_err};
    endfunction

    function automatic void model_edge(input bit c, input bit a, input bit b, input bit e);
        if (c) begin
            m_act = 0; m_done = 0; m_err = 0; m_opd = 0; m_k = 0;
        end else if (a || b) begin
            m_act = 1; m_done = 0; m_k = 0;
            m_opd = b && !a;
            m_err = a && b;
        end else begin
            m_err = 0;
            if (m_done) m_done = 0;
            else if (m_act && e) begin
                if (m_k == ITERS - 1) begin m_act = 0; m_done = 1; end
                else m_k++;
            end
        end
    endfunction

    // Per-scenario statistics gathered from the DUT outputs.
    int cyc, steps_seen, done_cnt, done_at, err_cnt, last_busy;

    task automatic clr_stats();
        cyc = 0; steps_seen = 0; done_cnt = 0; done_at = -1; err_cnt = 0; last_busy = -1;
    endtask

    // Called just after a negedge: drive, check mid-cycle, advance through the posedge.
    task automatic tick(input bit c, input bit a, input bit b, input bit e, input string name);
        clr = c; sm = a; sd = b; en = e;
        #1;
        check(name, {op_div, busy, step, iter, first, last, done, err}, model_out(e));
        if (step === 1'b1) steps_seen++;
        if (done === 1'b1) begin done_cnt++; done_at = cyc; end
        if (err === 1'b1) err_cnt++;
        if (busy === 1'b1) last_busy = cyc;
        @(posedge clk);
        model_edge(c, a, b, e);
        @(negedge clk);
        cyc++;
    endtask

    typedef struct {
        bit c, a, b, e;
        logic [7:0] exp;  // {op_div,busy,step,iter,first,last,done,err}
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{0, 0, 0, 1, 8'b0000_0000};
        tbl[1]  = '{0, 1, 0, 1, 8'b0000_0000};
        tbl[2]  = '{0, 0, 0, 1, 8'b0111_1000};
        tbl[3]  = '{0, 0, 0, 0, 8'b0100_0000};
        tbl[4]  = '{0, 0, 0, 1, 8'b0110_0100};
        tbl[5]  = '{0, 0, 0, 1, 8'b0100_0010};
        tbl[6]  = '{0, 1, 1, 1, 8'b0000_0000};
        tbl[7]  = '{0, 0, 0, 1, 8'b0111_1001};
        tbl[8]  = '{0, 0, 1, 1, 8'b0110_0100};
        tbl[9]  = '{0, 0, 0, 1, 8'b1111_1000};
        tbl[10] = '{1, 0, 0, 1, 8'b1110_0100};
        tbl[11] = '{0, 0, 0, 1, 8'b0000_0000};
        tbl[12] = '{0, 0, 0, 0, 8'b0000_0000};

        clr = 1; sm = 0; sd = 0; en = 0;
        clr2 = 1; sm2 = 0; sd2 = 0; en2 = 0;
        @(negedge clk);
        @(posedge clk);
        model_edge(1, 0, 0, 0);
        @(negedge clk);
        clr2 = 0;

        // Reset held a second cycle, then ten idle cycles.
        clr_stats();
        tick(1, 0, 0, 0, "reset");
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 0, "idle");

        // Basic multiply.
        clr_stats();
        tick(0, 1, 0, 1, "mult_start");
        for (int i = 1; i <= 35; i++) tick(0, 0, 0, 1, "mult_run");
        check("mult_steps", steps_seen, ITERS);
        check("mult_done_cycle", done_at, ITERS + 1);
        check("mult_done_count", done_cnt, 1);
        check("mult_last_busy", last_busy, ITERS + 1);

        // Divide with en low in cycles 5..7.
        clr_stats();
        tick(0, 0, 1, 1, "div_start");
        for (int i = 1; i <= 38; i++) tick(0, 0, 0, !(i >= 5 && i <= 7), "div_stall");
        check("div_steps", steps_seen, ITERS);
        check("div_done_cycle", done_at, 36);

        // Both starts together.
        clr_stats();
        tick(0, 1, 1, 1, "both_start");
        for (int i = 1; i <= 35; i++) tick(0, 0, 0, 1, "both_run");
        check("both_err_count", err_cnt, 1);
        check("both_steps", steps_seen, ITERS);
        check("both_done_cycle", done_at, ITERS + 1);

        // Divide restart in cycle 10 of a multiply.
        clr_stats();
        tick(0, 1, 0, 1, "rst_mult_start");
        for (int i = 1; i <= 9; i++) tick(0, 0, 0, 1, "restart_run");
        tick(0, 0, 1, 1, "restart_div");
        for (int i = 11; i <= 45; i++) tick(0, 0, 0, 1, "restart_run2");
        check("restart_steps", steps_seen, 10 + ITERS);
        check("restart_done_count", done_cnt, 1);
        check("restart_done_cycle", done_at, 10 + ITERS + 1);

        // clr in cycle 20 of a multiply, then a clean multiply.
        clr_stats();
        tick(0, 1, 0, 1, "abort_start");
        for (int i = 1; i <= 19; i++) tick(0, 0, 0, 1, "abort_run");
        tick(1, 0, 0, 1, "abort_clr");
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 1, "abort_idle");
        check("abort_done_count", done_cnt, 0);
        clr_stats();
        tick(0, 1, 0, 1, "clean_start");
        for (int i = 1; i <= 35; i++) tick(0, 0, 0, 1, "clean_run");
        check("clean_steps", steps_seen, ITERS);
        check("clean_done_cycle", done_at, ITERS + 1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit rc, ra, rb, re;
            rc = ($urandom_range(0, 299) == 0);
            ra = ($urandom_range(0, 59) == 0);
            rb = ($urandom_range(0, 59) == 0);
            re = ($urandom_range(0, 3) != 0);
            tick(rc, ra, rb, re, "random");
        end

        // Minimum configuration: ITERS=2, CNT_W=1.
        for (int i = 0; i < 13; i++) begin
            clr2 = tbl[i].c; sm2 = tbl[i].a; sd2 = tbl[i].b; en2 = tbl[i].e;
            #1;
            check($sformatf("min_cfg_row%0d", i),
                  {op_div2, busy2, step2, iter2, first2, last2, done2, err2}, tbl[i].exp);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
